tvm_buffer_read_seq: RTL and testbench
======================================

# tvm_buffer_read_seq

Read-side sequencer for the windowed `tvm_buffer`. It acts as the buffer's sole reader and, on a start command, drains a programmed number of read windows. For each window it walks the window offsets 0..RD_WINDOW-1 and presents each word on a valid/ready output stream, then advances the buffer read pointer. It sits between `tvm_buffer` and the downstream compute/DMA stage, replacing hand-driven read_advance/read_addr/read_ready control.

## Interface
Parameters:
- DATA_WIDTH, 256, buffer word width
- RD_WINDOW, 8, words per window; must equal the attached buffer's RD_WINDOW
- RD_ADDR_WIDTH, 3, log2(RD_WINDOW)
- NUM_WIDTH, 16, width of the window-count command

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  command strobe; sampled only in IDLE
- num_windows  in  NUM_WIDTH  windows to drain; latched on accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on completion
- buf_read_valid  in  1  from buffer: at least RD_WINDOW words present
- buf_read_data  in  DATA_WIDTH  from buffer: registered read data
- buf_read_ready  out  1  to buffer: read strobe
- buf_read_addr  out  RD_ADDR_WIDTH  to buffer: window offset
- buf_read_advance  out  1  to buffer: window advance
- out_valid  out  1  stream word valid
- out_ready  in  1  stream backpressure
- out_data  out  DATA_WIDTH  stream word
- out_last  out  1  marks the final word of the final window

## Operation
- Reset values: busy, done, buf_read_ready, buf_read_advance, out_valid and out_last are 0. buf_read_addr is 0. State is IDLE. The offset counter idx and the window counter wcnt are 0.
- States: IDLE, WAIT, FETCH, HOLD, ADVANCE, DONE.
- IDLE:
  - If start=1 and num_windows≠0: latch num_windows into nwin, clear idx and wcnt, go to WAIT.
  - If start=1 and num_windows=0: go to DONE. No buffer access occurs.
- WAIT: if buf_read_valid=1, go to FETCH; otherwise stay.
- FETCH: drive buf_read_ready=1 for exactly one cycle, then go to HOLD. buf_read_addr always equals idx.
- HOLD:
  - Drive out_valid=1. out_data is buf_read_data, passed through combinationally; it stays stable because buf_read_ready is low.
  - When out_valid and out_ready are both high, one beat is transferred.
  - On a beat with idx<RD_WINDOW-1: increment idx, go to FETCH.
  - On a beat with idx=RD_WINDOW-1: set idx to 0, go to ADVANCE.
  - If out_ready=0, stay in HOLD with out_valid held high and data stable.
- ADVANCE:
  - Drive buf_read_advance=1 for exactly one cycle and increment wcnt.
  - This state is only reached after WAIT has seen buf_read_valid=1, and this block is the sole reader, so the advance is always accepted.
  - Next state is DONE if wcnt+1=nwin, otherwise WAIT.
- DONE: done=1 for one cycle, then go to IDLE.
- out_last = HOLD & (idx=RD_WINDOW-1) & (wcnt=nwin-1).
- start is ignored while busy. num_windows changes after an accepted start have no effect.
- wcnt and nwin are both NUM_WIDTH wide, so up to 2^NUM_WIDTH-1 windows are supported.
- A reset in any state returns to IDLE on the next edge with all outputs at their reset values. A partially consumed window is discarded; the buffer must be reset alongside.

## Timing
- Buffer read latency is 1 cycle: read_ready is asserted in FETCH and the data is valid in the following HOLD cycle.
- Start to first out_valid is 3 cycles when buf_read_valid is already high (WAIT, FETCH, then HOLD).
- With out_ready held at 1, the rate is 1 word per 2 cycles. Each window costs 2·RD_WINDOW+2 cycles when buf_read_valid stays high.
- Each cycle spent in WAIT or in a stalled HOLD adds exactly one cycle.
- The buffer's status_counter updates on the edge ending ADVANCE, so the next WAIT samples the updated buf_read_valid.

## Test plan
- **Basic drain.** Preload 16 words (value = index), num_windows=2, out_ready=1, start at cycle 0.
  - Expected: first out_valid at cycle 3.
  - out_data sequence is 0..7 then the buffer's next window (buffer RD_ADVANCE=8).
  - buf_read_advance pulses at cycles 18 and 36, done at cycle 37, out_last only on beat 16.
- **Zero windows.** num_windows=0, start.
  - Expected: done at cycle 1, busy high for cycle 1 only, no buf_read_ready and no out_valid.
- **Starved buffer.** Hold buf_read_valid=0 for 10 cycles after start.
  - Expected: stays in WAIT, busy=1, no strobes; the first FETCH is the cycle after buf_read_valid rises.
- **Backpressure.** Drop out_ready for 5 cycles during beat 3.
  - Expected: out_valid held, out_data unchanged, no buf_read_ready pulses; total latency grows by exactly 5.
- **Start while busy.** Pulse start with num_windows=7 during window 0 of a 1-window job.
  - Expected: ignored; exactly 8 beats, one done pulse.
- **Mid-run reset.** Assert rst in HOLD of beat 4.
  - Expected: next cycle busy, out_valid, buf_read_* and done all 0, buf_read_addr=0; a new start runs normally.

Source files
------------

// File: rtl/tvm_buffer_read_seq_if.sv
// Buffer-read and output-stream signals of the tvm_buffer read sequencer.
// master = sequencer side, slave = buffer/consumer side.
interface tvm_buffer_read_seq_if #(
  parameter int DATA_WIDTH    = 256,
  parameter int RD_ADDR_WIDTH = 3
);
  logic                     buf_read_valid;
  logic [DATA_WIDTH-1:0]    buf_read_data;
  logic                     buf_read_ready;
  logic [RD_ADDR_WIDTH-1:0] buf_read_addr;
  logic                     buf_read_advance;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    out_data;
  logic                     out_last;

  modport master (
    input  buf_read_valid, buf_read_data, out_ready,
    output buf_read_ready, buf_read_addr, buf_read_advance,
           out_valid, out_data, out_last
  );

  modport slave (
    output buf_read_valid, buf_read_data, out_ready,
    input  buf_read_ready, buf_read_addr, buf_read_advance,
           out_valid, out_data, out_last
  );
endinterface

// File: rtl/tvm_buffer_read_seq.sv
// Read-side sequencer for tvm_buffer: on start, drains nwin windows of
// RD_WINDOW words each onto a valid/ready stream, advancing the buffer
// read pointer after every window.
module tvm_buffer_read_seq #(
  parameter int DATA_WIDTH    = 256,
  parameter int RD_WINDOW     = 8,
  parameter int RD_ADDR_WIDTH = 3,
  parameter int NUM_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_WIDTH-1:0] num_windows,
  output logic                 busy,
  output logic                 done,
  tvm_buffer_read_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_FETCH,
    S_HOLD,
    S_ADVANCE,
    S_DONE
  } state_t;

  localparam logic [RD_ADDR_WIDTH-1:0] LAST_IDX = RD_ADDR_WIDTH'(RD_WINDOW - 1);

  state_t                   r_state, w_state_nxt;
  logic [RD_ADDR_WIDTH-1:0] r_idx, w_idx_nxt;
  logic [NUM_WIDTH-1:0]     r_wcnt, w_wcnt_nxt;
  logic [NUM_WIDTH-1:0]     r_nwin, w_nwin_nxt;
  logic                     w_last_idx;
  logic                     w_last_win;
  logic [DATA_WIDTH-1:0]    w_data;

  assign w_last_idx = (r_idx == LAST_IDX);
  // wcnt+1 == nwin, written as wcnt == nwin-1 (nwin is never 0 once latched)
  assign w_last_win = (r_wcnt == r_nwin - NUM_WIDTH'(1));

  // Buffer data is registered inside the buffer and held while read_ready is low
  assign w_data           = bus.buf_read_data;
  assign bus.out_data     = w_data;
  assign bus.buf_read_addr = r_idx;

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_wcnt  <= '0;
      r_nwin  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_nwin  <= w_nwin_nxt;
    end
  end

  // Next-state, counter updates and state-decoded outputs
  always_comb begin
    w_state_nxt          = r_state;
    w_idx_nxt            = r_idx;
    w_wcnt_nxt           = r_wcnt;
    w_nwin_nxt           = r_nwin;
    busy                 = (r_state != S_IDLE);
    done                 = 1'b0;
    bus.buf_read_ready   = 1'b0;
    bus.buf_read_advance = 1'b0;
    bus.out_valid        = 1'b0;
    bus.out_last         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (num_windows != '0) begin
            w_nwin_nxt  = num_windows;
            w_idx_nxt   = '0;
            w_wcnt_nxt  = '0;
            w_state_nxt = S_WAIT;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_WAIT: begin
        if (bus.buf_read_valid) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        bus.buf_read_ready = 1'b1;
        w_state_nxt        = S_HOLD;
      end
      S_HOLD: begin
        bus.out_valid = 1'b1;
        bus.out_last  = w_last_idx && w_last_win;
        if (bus.out_ready) begin
          if (w_last_idx) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_ADVANCE;
          end else begin
            w_idx_nxt   = r_idx + RD_ADDR_WIDTH'(1);
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_ADVANCE: begin
        bus.buf_read_advance = 1'b1;
        w_wcnt_nxt           = r_wcnt + NUM_WIDTH'(1);
        w_state_nxt          = w_last_win ? S_DONE : S_WAIT;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tvm_buffer_read_seq.sv
// Bench for tvm_buffer_read_seq: a simple windowed-buffer model feeds the
// sequencer; an expected-word queue built from the job description is
// checked on every cycle, plus literal cycle-timing expectations per scenario.
module tb_tvm_buffer_read_seq;

  localparam int DW = 256;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] num_windows;
  logic        busy;
  logic        done;

  tvm_buffer_read_seq_if #(.DATA_WIDTH(DW), .RD_ADDR_WIDTH(3)) bus ();

  tvm_buffer_read_seq #(
    .DATA_WIDTH(DW),
    .RD_WINDOW(8),
    .RD_ADDR_WIDTH(3),
    .NUM_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .num_windows(num_windows),
    .busy(busy),
    .done(done),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Windowed buffer model: window = 8 words, advance by 8, 1-cycle read latency
  logic [DW-1:0] mem [0:63];
  logic [DW-1:0] bm_data;
  int            bm_rd_ptr;
  int            wr_cnt;
  logic          starve;

  always @(posedge clk) begin
    if (rst) begin
      bm_rd_ptr <= 0;
    end else begin
      if (bus.buf_read_ready) bm_data <= mem[bm_rd_ptr + int'(bus.buf_read_addr)];
      if (bus.buf_read_advance) bm_rd_ptr <= bm_rd_ptr + 8;
    end
  end

  assign bus.buf_read_data  = bm_data;
  assign bus.buf_read_valid = !starve && ((wr_cnt - bm_rd_ptr) >= 8);

  // Scoreboard and per-job records
  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_err    = 0;
  int t0       = -100;

  int adv_q[$];
  int done_q[$];
  int first_valid, first_fetch, beats, fetches, valids, busy_cnt, lasts, last_beat, win_beats;
  logic          prev_stall;
  logic [DW-1:0] prev_data;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk_d(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Compare process: every cycle, away from the active edge
  initial begin
    int rel;
    win_beats  = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        win_beats  = 0;
        prev_stall = 1'b0;
      end else begin
        if (edge_cnt == t0) begin
          adv_q.delete();
          done_q.delete();
          first_valid = -1; first_fetch = -1;
          beats = 0; fetches = 0; valids = 0; busy_cnt = 0;
          lasts = 0; last_beat = -1; win_beats = 0;
        end
        rel = edge_cnt - t0;
        if (busy) busy_cnt++;
        if (bus.buf_read_ready) begin
          fetches++;
          if (first_fetch < 0) first_fetch = rel;
          chk("fetch_addr", int'(bus.buf_read_addr), win_beats);
          chk("fetch_vs_valid", int'(bus.out_valid), 0);
        end
        if (bus.out_valid) begin
          valids++;
          if (first_valid < 0) first_valid = rel;
          if (prev_stall) chk_d("stall_data", bus.out_data, prev_data);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_valid: got out_valid=1, expected no word pending (t=%0t)", $time);
          end else begin
            chk_d("out_data", bus.out_data, exp_q[0].data);
            chk("out_last", int'(bus.out_last), int'(exp_q[0].last));
            if (bus.out_ready) begin
              beats++;
              win_beats++;
              if (bus.out_last) begin
                lasts++;
                last_beat = beats;
              end
              void'(exp_q.pop_front());
            end
          end
        end else begin
          chk("last_idle", int'(bus.out_last), 0);
        end
        if (bus.buf_read_advance) begin
          chk("adv_window_beats", win_beats, 8);
          adv_q.push_back(rel);
          win_beats = 0;
        end
        if (done) done_q.push_back(rel);
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic preload(input int n);
    for (int i = 0; i < 64; i++) mem[i] = DW'(i) | (DW'(i) << 128);
    wr_cnt = n;
  endtask

  // Drives a one-cycle start; returns one cycle later (rel 1, just after the edge)
  task automatic start_job(input int n);
    exp_t e;
    @(posedge clk); #1;
    t0          = edge_cnt;
    start       = 1'b1;
    num_windows = 16'(n);
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 8; k++) begin
        e.data = mem[bm_rd_ptr + 8 * w + k];
        e.last = (w == n - 1) && (k == 7);
        exp_q.push_back(e);
      end
    end
    @(posedge clk); #1;
    start       = 1'b0;
    num_windows = 16'd5;
  endtask

  task automatic wait_rel(input int r);
    while (edge_cnt < t0 + r) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_q.size() == 0 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk("done_seen", int'(done_q.size() > 0), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_idle(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_rd_ready"}, int'(bus.buf_read_ready), 0);
    chk({tag, "_rd_addr"}, int'(bus.buf_read_addr), 0);
    chk({tag, "_rd_adv"}, int'(bus.buf_read_advance), 0);
    chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_out_last"}, int'(bus.out_last), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    num_windows   = '0;
    bus.out_ready = 1'b1;
    starve        = 1'b0;
    wr_cnt        = 0;
    preload(0);

    // Reset state
    do_reset();
    @(negedge clk);
    chk_outputs_idle("reset");

    // Basic drain: 2 windows of preloaded index values
    preload(16);
    start_job(2);
    wait_done(200);
    chk("basic_first_valid", first_valid, 3);
    chk("basic_adv_count", adv_q.size(), 2);
    chk("basic_adv0", adv_q[0], 18);
    chk("basic_adv1", adv_q[1], 36);
    chk("basic_done", done_q[0], 37);
    chk("basic_beats", beats, 16);
    chk("basic_lasts", lasts, 1);
    chk("basic_last_beat", last_beat, 16);
    chk("basic_q_empty", exp_q.size(), 0);

    // Zero windows: straight to DONE, no buffer access
    start_job(0);
    wait_done(20);
    chk("zero_done", done_q[0], 1);
    chk("zero_busy_cycles", busy_cnt, 1);
    chk("zero_fetches", fetches, 0);
    chk("zero_valids", valids, 0);

    // Starved buffer: valid withheld for 10 cycles after start
    do_reset();
    preload(8);
    starve = 1'b1;
    start_job(1);
    repeat (10) @(posedge clk);
    #1 starve = 1'b0;
    wait_done(200);
    chk("starve_first_fetch", first_fetch, 12);
    chk("starve_first_valid", first_valid, 13);
    chk("starve_adv", adv_q[0], 28);
    chk("starve_done", done_q[0], 29);
    chk("starve_busy_cycles", busy_cnt, 29);
    chk("starve_beats", beats, 8);

    // Backpressure: out_ready low for 5 cycles on the third word
    do_reset();
    preload(8);
    start_job(1);
    wait_rel(7);
    bus.out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_done(200);
    chk("bp_first_valid", first_valid, 3);
    chk("bp_adv", adv_q[0], 23);
    chk("bp_done", done_q[0], 24);
    chk("bp_beats", beats, 8);
    chk("bp_fetches", fetches, 8);

    // Start while busy is ignored
    do_reset();
    preload(8);
    start_job(1);
    wait_rel(5);
    start       = 1'b1;
    num_windows = 16'd7;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(200);
    repeat (25) @(posedge clk);
    @(negedge clk);
    chk("busy_start_done_count", done_q.size(), 1);
    chk("busy_start_done", done_q[0], 19);
    chk("busy_start_beats", beats, 8);
    chk("busy_start_fetches", fetches, 8);
    chk("busy_start_idle", int'(busy), 0);

    // Mid-run reset in HOLD of the fourth word, then a normal job
    do_reset();
    preload(8);
    start_job(1);
    wait_rel(9);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk_outputs_idle("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    start_job(1);
    wait_done(200);
    chk("midrst_done", done_q[0], 19);
    chk("midrst_beats", beats, 8);
    chk("midrst_lasts", lasts, 1);
    chk("midrst_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
